pc_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS core; sits directly upstream of the decode-stage control unit.
- Owns the PC register and the IF/ID pipeline register.
- Drives instruction-memory fetches and consumes the control unit's PC-select code (PFU op) and stall flag.
- Resolves jumps and branches with one architectural delay slot; holds a redirect pending across instruction-memory wait states.

---
 rtl/pc_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID register and jump/branch
// resolution with one delay slot; a redirect survives imem wait states.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [2:0]  pc_src,
  input  logic [31:0] rs_data,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus8,
  output logic        id_valid,
  output logic        redirect
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PEND  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_t_q, pend_t_d;
  logic        redir_q, redir_d;

  logic        is_o16, is_o26, is_jmp, is_rs;
  logic        take;
  logic [31:0] pcn;
  logic [31:0] target;

  assign is_o16 = (pc_src == 3'd1);
  assign is_o26 = (pc_src == 3'd2);
  assign is_jmp = (pc_src == 3'd3);
  assign is_rs  = (pc_src == 3'd4);

  assign take = ifid_q.valid & ~stall
              & (is_o16 | is_o26 | is_jmp | is_rs);
  assign pcn  = ifid_q.pc + 32'd4;

  always_comb begin
    target = pcn;
    unique case (1'b1)
      is_o16: target = pcn
        + {{14{ifid_q.instr[15]}}, ifid_q.instr[15:0], 2'b00};
      is_o26: target = pcn
        + {{4{ifid_q.instr[25]}}, ifid_q.instr[25:0], 2'b00};
      is_jmp: target = {pcn[31:28], ifid_q.instr[25:0], 2'b00};
      is_rs:  target = rs_data;
      default: target = pcn;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ifid_q   <= '{instr: NOP_INSTR, pc: 32'd0, valid: 1'b0};
      pend_v_q <= 1'b0;
      pend_t_q <= 32'd0;
      redir_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      redir_q  <= redir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH, PEND: begin
        if (!stall) begin
          if (imem_ready)
            state_d = FETCH;
          else if (take)
            state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      FETCH, PEND: imem_req = 1'b1;
      default:     imem_req = 1'b0;
    endcase
  end

  // Stall freezes everything; a missing word becomes a bubble.
  always_comb begin
    pc_d     = pc_q;
    ifid_d   = ifid_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    redir_d  = take;
    if (state_q == IDLE) begin
      if (!stall)
        ifid_d = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};
    end else if (!stall) begin
      if (imem_ready) begin
        ifid_d   = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
        pend_v_d = 1'b0;
        if (take)
          pc_d = target;
        else if (pend_v_q)
          pc_d = pend_t_q;
        else
          pc_d = pc_q + 32'd4;
      end else begin
        ifid_d = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};
        if (take) begin
          pend_v_d = 1'b1;
          pend_t_d = target;
        end
      end
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = ifid_q.instr;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus8 = ifid_q.pc + 32'd8;
  assign id_valid    = ifid_q.valid;
  assign redirect    = redir_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: transaction-level model checked
// every cycle, plus literal pins at the interesting points.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  pc_src;
  logic [31:0] rs_data;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus8;
  logic        id_valid;
  logic        redirect;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  // model of architectural state
  logic        m_idle;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic        m_valid;
  logic        m_pend;
  logic [31:0] m_ptgt;
  logic        m_redir;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pc_src(pc_src), .rs_data(rs_data),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus8(id_pc_plus8), .id_valid(id_valid),
    .redirect(redirect)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_3004: return 32'h1000_0003;
      32'h0000_3014: return 32'h0800_0C40;
      32'h0000_0000: return 32'h1000_8000;
      32'hFFFE_0004: return 32'h0800_0010;
      default:       return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] model_tgt(input logic [2:0] src,
      input logic [31:0] ins, input logic [31:0] ipc,
      input logic [31:0] rs);
    logic [31:0] pcn;
    int off16, off26;
    pcn   = ipc + 32'd4;
    off16 = int'($signed(ins[15:0])) * 4;
    off26 = int'($signed(ins[25:0])) * 4;
    case (src)
      3'd1:    return pcn + 32'(off16);
      3'd2:    return pcn + 32'(off26);
      3'd3:    return (pcn & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
      3'd4:    return rs;
      default: return pcn;
    endcase
  endfunction

  task automatic model_reset();
    m_idle  = 1'b1;
    m_pc    = 32'h0000_3000;
    m_instr = 32'h0;
    m_idpc  = 32'h0;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_ptgt  = 32'h0;
    m_redir = 1'b0;
  endtask

  task automatic step(input logic s, input logic r,
                      input logic [2:0] src, input logic [31:0] rs);
    logic tk;
    logic [31:0] tg;
    logic [31:0] word;
    stall      = s;
    imem_ready = r;
    pc_src     = src;
    rs_data    = rs;
    word       = mem_rd(m_pc);
    imem_rdata = word;
    tk = !m_idle && !s && m_valid && (src >= 3'd1) && (src <= 3'd4);
    tg = model_tgt(src, m_instr, m_idpc, rs);
    @(posedge clk);
    #1;
    if (m_idle) begin
      m_idle = 1'b0;
      if (!s) begin
        m_instr = 32'h0;
        m_valid = 1'b0;
      end
    end else if (!s) begin
      if (r) begin
        m_instr = word;
        m_idpc  = m_pc;
        m_valid = 1'b1;
        m_pc    = tk ? tg : (m_pend ? m_ptgt : m_pc + 32'd4);
        m_pend  = 1'b0;
      end else begin
        m_instr = 32'h0;
        m_valid = 1'b0;
        if (tk) begin
          m_pend = 1'b1;
          m_ptgt = tg;
        end
      end
    end
    m_redir = tk;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", 32'(imem_req), 32'(!m_idle));
      chk("id_instr", id_instr, m_instr);
      chk("id_pc", id_pc, m_idpc);
      chk("id_pc_plus8", id_pc_plus8, m_idpc + 32'd8);
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("redirect", 32'(redirect), 32'(m_redir));
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_src = 3'd0;
    rs_data = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h3000);

    // sequential fetch
    step(0, 1, 0, 0);
    chk("idle_exit_req", 32'(imem_req), 32'h1);
    step(0, 1, 0, 0);
    chk("seq_id_pc", id_pc, 32'h3000);
    chk("seq_valid", 32'(id_valid), 32'h1);
    step(0, 1, 0, 0);
    chk("seq_addr", imem_addr, 32'h3008);

    // beq at 0x3004, imm 3, memory ready
    step(0, 1, 1, 0);
    chk("beq_addr", imem_addr, 32'h3014);
    chk("beq_slot_pc", id_pc, 32'h3008);
    chk("beq_redir", 32'(redirect), 32'h1);
    step(0, 1, 0, 0);
    chk("beq_redir_once", 32'(redirect), 32'h0);

    // jr back to 0x3000 to revisit the branch
    step(0, 1, 4, 32'h3000);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("beq2_in_id", id_pc, 32'h3004);

    // same branch across two wait states
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("pend_addr", imem_addr, 32'h3008);
    chk("pend_bubble", 32'(id_valid), 32'h0);
    step(0, 1, 0, 0);
    chk("pend_slot_pc", id_pc, 32'h3008);
    chk("pend_target", imem_addr, 32'h3014);
    step(0, 1, 0, 0);

    // j at 0x3014 held by stall for 3 cycles
    step(1, 1, 3, 0);
    step(1, 1, 3, 0);
    step(1, 1, 3, 0);
    chk("stall_addr", imem_addr, 32'h3018);
    chk("stall_id_pc", id_pc, 32'h3014);
    chk("stall_instr", id_instr, 32'h0800_0C40);
    chk("stall_redir", 32'(redirect), 32'h0);
    step(0, 1, 3, 0);
    chk("jump_addr", imem_addr, 32'h3100);
    step(0, 1, 0, 0);

    // jr to 0x4000, then to 0x0 for the wrapping branch
    step(0, 1, 4, 32'h4000);
    chk("jr_addr", imem_addr, 32'h4000);
    step(0, 1, 0, 0);
    step(0, 1, 4, 32'h0);
    step(0, 1, 0, 0);
    chk("zero_pc8", id_pc_plus8, 32'h8);
    step(0, 1, 1, 0);
    chk("wrap_addr", imem_addr, 32'hFFFE_0004);
    step(0, 1, 5, 0);
    chk("code5_addr", imem_addr, 32'hFFFE_0008);
    chk("code5_redir", 32'(redirect), 32'h0);
    step(0, 1, 2, 0);
    chk("off26_addr", imem_addr, 32'hFFFE_0048);
    step(0, 1, 0, 0);

    // enter PEND, then reset mid-cycle
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("pre_rst_pend_addr", imem_addr, 32'hFFFE_004C);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_addr", imem_addr, 32'h3000);
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_valid", 32'(id_valid), 32'h0);
    chk("arst_id_pc", id_pc, 32'h0);
    chk("arst_redir", 32'(redirect), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("restart_addr", imem_addr, 32'h3004);
    step(0, 1, 0, 0);
    chk("restart_seq", imem_addr, 32'h3008);
    @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
